// File: rtl/object_pose_bank_if.sv
// object_pose_bank_if: steering, clear and read-port signals of the pose bank
interface object_pose_bank_if #(
  parameter int W  = 16,
  parameter int IW = 2
);
  logic          frame_tick;
  logic [IW-1:0] obj_sel;
  logic [11:0]   controlPad;
  logic          obj_clr;
  logic [IW-1:0] rd_idx;
  logic [W-1:0]  Xc, Yc, Zc;
  logic [W-1:0]  angleX, angleY, angleZ;
  logic          upd_done;
  modport master (
    output frame_tick, obj_sel, controlPad, obj_clr, rd_idx,
    input  Xc, Yc, Zc, angleX, angleY, angleZ, upd_done
  );
  modport slave (
    input  frame_tick, obj_sel, controlPad, obj_clr, rd_idx,
    output Xc, Yc, Zc, angleX, angleY, angleZ, upd_done
  );
endinterface

// File: rtl/object_pose_bank.sv
// object_pose_bank: per-object pose registers steered by controlPad once per frame, with a registered read port
module object_pose_bank #(
  parameter int          W          = 16,
  parameter int          NOBJ       = 4,
  parameter logic [15:0] POS_STEP   = 16'h0020,
  parameter logic [15:0] ANG_STEP   = 16'h0020,
  parameter logic [15:0] Z_INIT     = 16'h0640,
  parameter logic [15:0] POS_LIM    = 16'h1000,
  parameter logic [15:0] Z_MIN      = 16'h0100,
  parameter logic [15:0] Z_MAX      = 16'h3E80,
  parameter logic [15:0] PI_Q       = 16'h6488,
  parameter int          ACC_FRAMES = 8
) (
  input logic             fclk,
  input logic             rst_n,
  object_pose_bank_if.slave bus
);
  localparam int IW = $clog2(NOBJ);
  localparam int HW = $clog2(ACC_FRAMES + 1);
  typedef logic signed [W-1:0] word_t;
  typedef logic signed [W:0]   pos_t;
  typedef logic signed [W+1:0] ang_t;
  typedef struct packed {
    word_t x, y, z, ax, ay, az;
  } pose_t;
  localparam pose_t POSE_RST = '{x: '0, y: '0, z: word_t'(Z_INIT), ax: '0, ay: '0, az: '0};
  localparam pos_t  P_HI   = pos_t'(POS_LIM);
  localparam pos_t  P_LO   = -P_HI;
  localparam pos_t  Z_LO   = pos_t'(Z_MIN);
  localparam pos_t  Z_HI   = pos_t'(Z_MAX);
  localparam pos_t  P_STEP = pos_t'(POS_STEP);
  localparam ang_t  A_STEP = ang_t'(ANG_STEP);
  localparam ang_t  A_PI   = ang_t'(PI_Q);
  localparam ang_t  A_NPI  = -A_PI;
  localparam ang_t  A_2PI  = A_PI + A_PI;
  localparam logic [HW-1:0] HMAX = HW'(ACC_FRAMES);
  function automatic word_t clamp(input word_t v, input pos_t d, input pos_t lo, input pos_t hi);
    pos_t s;
    s = pos_t'(v) + d;
    return s > hi ? word_t'(hi) : s < lo ? word_t'(lo) : word_t'(s);
  endfunction
  function automatic word_t wrap(input word_t a, input ang_t d);
    ang_t s;
    s = ang_t'(a) + d;
    return s > A_PI ? word_t'(s - A_2PI) : s < A_NPI ? word_t'(s + A_2PI) : word_t'(s);
  endfunction
  function automatic pos_t pdir(input logic [1:0] p, input pos_t st);
    return p == 2'b10 ? st : p == 2'b01 ? -st : '0;
  endfunction
  function automatic ang_t adir(input logic [1:0] p, input ang_t st);
    return p == 2'b10 ? st : p == 2'b01 ? -st : '0;
  endfunction
  pose_t         pose_q [NOBJ];
  pose_t         pose_d [NOBJ];
  pose_t         out_q;
  logic [HW-1:0] hold_q, hold_d, hold_nx;
  logic [11:0]   last_pad_q, last_pad_d;
  logic [IW-1:0] last_sel_q, last_sel_d;
  logic          upd_q, upd_d;
  logic          sel_ok, rd_ok, tick, same, fast;
  pos_t          pst;
  ang_t          ast;
  logic [11:0]   pad;
  assign pad     = bus.controlPad;
  assign sel_ok  = {1'b0, bus.obj_sel} < (IW+1)'(NOBJ);
  assign rd_ok   = {1'b0, bus.rd_idx} < (IW+1)'(NOBJ);
  assign tick    = bus.frame_tick & sel_ok;
  assign same    = pad != '0 && pad == last_pad_q && bus.obj_sel == last_sel_q;
  assign hold_nx = same ? (hold_q == HMAX ? hold_q : hold_q + HW'(1)) : '0;
  // The step doubles on the very tick whose updated count reaches the limit
  assign fast    = hold_nx == HMAX;
  assign pst     = fast ? P_STEP + P_STEP : P_STEP;
  assign ast     = fast ? A_STEP + A_STEP : A_STEP;
  always_comb begin
    pose_d     = pose_q;
    hold_d     = hold_q;
    last_pad_d = last_pad_q;
    last_sel_d = last_sel_q;
    upd_d      = tick;
    if (tick) begin
      hold_d     = hold_nx;
      last_pad_d = pad;
      last_sel_d = bus.obj_sel;
    end
    if (sel_ok && bus.obj_clr) begin
      hold_d               = '0;
      pose_d[bus.obj_sel]  = POSE_RST;
    end else if (tick) begin
      pose_d[bus.obj_sel].x  = clamp(pose_q[bus.obj_sel].x, -pdir(pad[9:8], pst), P_LO, P_HI);
      pose_d[bus.obj_sel].y  = clamp(pose_q[bus.obj_sel].y, -pdir(pad[7:6], pst), P_LO, P_HI);
      pose_d[bus.obj_sel].z  = clamp(pose_q[bus.obj_sel].z, pdir(pad[11:10], pst), Z_LO, Z_HI);
      pose_d[bus.obj_sel].ax = wrap(pose_q[bus.obj_sel].ax, adir(pad[5:4], ast));
      pose_d[bus.obj_sel].ay = wrap(pose_q[bus.obj_sel].ay, adir(pad[3:2], ast));
      pose_d[bus.obj_sel].az = wrap(pose_q[bus.obj_sel].az, adir(pad[1:0], ast));
    end
  end
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NOBJ; i++) pose_q[i] <= POSE_RST;
      out_q      <= POSE_RST;
      hold_q     <= '0;
      last_pad_q <= '0;
      last_sel_q <= '0;
      upd_q      <= 1'b0;
    end else begin
      pose_q     <= pose_d;
      hold_q     <= hold_d;
      last_pad_q <= last_pad_d;
      last_sel_q <= last_sel_d;
      upd_q      <= upd_d;
      if (rd_ok) out_q <= pose_q[bus.rd_idx];
    end
  end
  assign bus.Xc       = out_q.x;
  assign bus.Yc       = out_q.y;
  assign bus.Zc       = out_q.z;
  assign bus.angleX   = out_q.ax;
  assign bus.angleY   = out_q.ay;
  assign bus.angleZ   = out_q.az;
  assign bus.upd_done = upd_q;
endmodule

// File: tb/tb_object_pose_bank.sv
// tb_object_pose_bank: randomized and directed stimulus checked every cycle against an integer pose model
module tb_object_pose_bank;
  localparam int ZI = 1600, PLIM = 4096, ZMN = 256, ZMX = 16000, PI = 25736;
  logic fclk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0, n_bad = 0;
  object_pose_bank_if #(.W(16), .IW(2)) bus ();
  object_pose_bank dut (.fclk(fclk), .rst_n(rst_n), .bus(bus));
  always #5 fclk = ~fclk;
  int         mx[4], my[4], mz[4], max_[4], may[4], maz[4];
  int         mh, mls;
  logic [11:0] mlp;
  int         ex, ey, ez, eax, eay, eaz, eu;
  function automatic int dirv(input logic [1:0] p);
    return p == 2'b10 ? 1 : p == 2'b01 ? -1 : 0;
  endfunction
  function automatic int clampi(input int v, input int lo, input int hi);
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
  function automatic int wrapi(input int v);
    return v > PI ? v - 2 * PI : v < -PI ? v + 2 * PI : v;
  endfunction
  function automatic int nhold();
    if (bus.controlPad != 0 && bus.controlPad == mlp && int'(bus.obj_sel) == mls)
      return mh < 8 ? mh + 1 : 8;
    return 0;
  endfunction
  function automatic int stp();
    return nhold() == 8 ? 64 : 32;
  endfunction
  always @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mx[i] <= 0; my[i] <= 0; mz[i] <= ZI; max_[i] <= 0; may[i] <= 0; maz[i] <= 0;
      end
      mh <= 0; mls <= 0; mlp <= '0;
      ex <= 0; ey <= 0; ez <= ZI; eax <= 0; eay <= 0; eaz <= 0; eu <= 0;
    end else begin
      ex <= mx[bus.rd_idx]; ey <= my[bus.rd_idx]; ez <= mz[bus.rd_idx];
      eax <= max_[bus.rd_idx]; eay <= may[bus.rd_idx]; eaz <= maz[bus.rd_idx];
      eu <= int'(bus.frame_tick);
      if (bus.frame_tick) begin
        mh <= nhold(); mlp <= bus.controlPad; mls <= int'(bus.obj_sel);
      end
      if (bus.obj_clr) begin
        mh <= 0;
        mx[bus.obj_sel] <= 0; my[bus.obj_sel] <= 0; mz[bus.obj_sel] <= ZI;
        max_[bus.obj_sel] <= 0; may[bus.obj_sel] <= 0; maz[bus.obj_sel] <= 0;
      end else if (bus.frame_tick) begin
        mx[bus.obj_sel] <= clampi(mx[bus.obj_sel] - dirv(bus.controlPad[9:8]) * stp(), -PLIM, PLIM);
        my[bus.obj_sel] <= clampi(my[bus.obj_sel] - dirv(bus.controlPad[7:6]) * stp(), -PLIM, PLIM);
        mz[bus.obj_sel] <= clampi(mz[bus.obj_sel] + dirv(bus.controlPad[11:10]) * stp(), ZMN, ZMX);
        max_[bus.obj_sel] <= wrapi(max_[bus.obj_sel] + dirv(bus.controlPad[5:4]) * stp());
        may[bus.obj_sel] <= wrapi(may[bus.obj_sel] + dirv(bus.controlPad[3:2]) * stp());
        maz[bus.obj_sel] <= wrapi(maz[bus.obj_sel] + dirv(bus.controlPad[1:0]) * stp());
      end
    end
  end
  task automatic chk(input string n, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", n, $time, act, exp);
    end
  endtask
  always @(negedge fclk) begin
    chk("Xc", int'($signed(bus.Xc)), ex);
    chk("Yc", int'($signed(bus.Yc)), ey);
    chk("Zc", int'($signed(bus.Zc)), ez);
    chk("angleX", int'($signed(bus.angleX)), eax);
    chk("angleY", int'($signed(bus.angleY)), eay);
    chk("angleZ", int'($signed(bus.angleZ)), eaz);
    chk("upd_done", int'(bus.upd_done), eu);
  end
  task automatic tick(input logic [1:0] s, input logic [11:0] p, input logic c);
    @(posedge fclk); #1;
    bus.obj_sel = s; bus.controlPad = p; bus.obj_clr = c; bus.frame_tick = 1'b1;
    @(posedge fclk); #1;
    bus.frame_tick = 1'b0; bus.obj_clr = 1'b0;
  endtask
  task automatic settle();
    @(posedge fclk); #2;
  endtask
  initial begin
    bus.frame_tick = 1'b0; bus.obj_sel = '0; bus.controlPad = '0; bus.obj_clr = 1'b0; bus.rd_idx = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge fclk);
    #1 rst_n = 1'b1;
    settle();
    chk("lit_rst_Zc", int'(bus.Zc), 16'h0640);
    chk("lit_rst_Xc", int'(bus.Xc), 0);
    chk("lit_rst_angleZ", int'(bus.angleZ), 0);
    chk("lit_rst_upd", int'(bus.upd_done), 0);
    tick(2'd0, 12'h800, 1'b0);
    chk("lit_upd_pulse", int'(bus.upd_done), 1);
    settle();
    chk("lit_fwd_Zc", int'(bus.Zc), 16'h0660);
    chk("lit_upd_low", int'(bus.upd_done), 0);
    bus.rd_idx = 2'd1;
    for (int i = 1; i <= 10; i++) begin
      tick(2'd1, 12'h200, 1'b0);
      if (i >= 8) begin
        settle();
        chk($sformatf("lit_hold_X_%0d", i), int'($signed(bus.Xc)), i == 8 ? -256 : i == 9 ? -320 : -384);
      end
    end
    bus.rd_idx = 2'd2;
    for (int i = 0; i < 804; i++) tick(2'd2, i % 2 ? 12'hC02 : 12'h002, 1'b0);
    settle();
    chk("lit_ang_pre", int'(bus.angleZ), 16'h6480);
    tick(2'd2, 12'h002, 1'b0);
    settle();
    chk("lit_ang_wrap", int'(bus.angleZ), 16'h9B90);
    bus.rd_idx = 2'd0;
    repeat (2000) tick(2'd0, 12'h800, 1'b0);
    settle();
    chk("lit_zmax", int'(bus.Zc), 16'h3E80);
    repeat (2000) tick(2'd0, 12'h400, 1'b0);
    settle();
    chk("lit_zmin", int'(bus.Zc), 16'h0100);
    bus.rd_idx = 2'd1;
    repeat (5) tick(2'd1, 12'hFFF, 1'b0);
    settle();
    chk("lit_pad11_X", int'($signed(bus.Xc)), -384);
    repeat (10) tick(2'd1, 12'h200, 1'b0);
    bus.rd_idx = 2'd0;
    tick(2'd0, 12'h200, 1'b0);
    settle();
    chk("lit_sel_switch_X", int'($signed(bus.Xc)), -32);
    for (int c = 0; c < 600; c++) begin
      @(posedge fclk); #1;
      bus.frame_tick = ($urandom % 3) == 0;
      if ($urandom % 4 == 0) bus.controlPad = 12'($urandom);
      if ($urandom % 8 == 0) bus.obj_sel = 2'($urandom);
      bus.obj_clr = ($urandom % 25) == 0;
      bus.rd_idx = 2'($urandom);
    end
    @(posedge fclk); #1;
    bus.frame_tick = 1'b0; bus.obj_clr = 1'b0;
    bus.rd_idx = 2'd3;
    tick(2'd3, 12'h800, 1'b1);
    chk("lit_clr_upd", int'(bus.upd_done), 1);
    settle();
    chk("lit_clr_Zc", int'(bus.Zc), 16'h0640);
    chk("lit_clr_Xc", int'(bus.Xc), 0);
    repeat (20) tick(2'($urandom), 12'($urandom), 1'b0);
    bus.rd_idx = 2'd2;
    @(posedge fclk); #3;
    rst_n = 1'b0;
    #1;
    chk("lit_async_Zc", int'(bus.Zc), 16'h0640);
    chk("lit_async_angleZ", int'(bus.angleZ), 0);
    repeat (2) @(posedge fclk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.rd_idx = 2'(i);
      settle();
      chk($sformatf("lit_post_rst_Zc_%0d", i), int'(bus.Zc), 16'h0640);
    end
    repeat (3) @(posedge fclk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
